// File: rtl/toy_fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch redirect controller.
package toy_fetch_redirect_ctrl_pkg;

    localparam int REDIR_SRC_NUM = 3;
    localparam int ADDR_WIDTH    = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CANCEL   = 2'd1,
        SETTLE   = 2'd2,
        REDIRECT = 2'd3
    } redir_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
    } redir_req_pkg;

endpackage

// File: rtl/toy_fetch_redirect_ctrl_arb.sv
// Fixed-priority arbiter: lowest requesting index wins. Gives one-hot grant and binary index.
module toy_fixed_prio_arb #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  vld_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Isolate the lowest set bit.
    assign gnt_o = vld_i & (~vld_i + N'(1));
    assign any_o = |vld_i;

    // Scan from the top so the lowest valid index is written last.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vld_i[i]) idx_o = IW'(i);
        end
    end

endmodule

// File: rtl/toy_fetch_redirect_ctrl.sv
// Front-end flush sequencer for pipeline redirects: arbitrate, pulse cancel_en, stall for a
// settle window, then hand the winning PC to PC-gen. Older (lower-index) redirects preempt.
// Optional perf counters are enabled with macro TOY_FETCH_REDIRECT_PERF_EN.
module toy_fetch_redirect_ctrl
    import toy_fetch_redirect_ctrl_pkg::*;
#(
    parameter int NUM_SRC       = REDIR_SRC_NUM,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_SRC-1:0]                 v_redir_req_vld,
    output logic [NUM_SRC-1:0]                 v_redir_req_rdy,
    input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0] v_redir_req_pc,
    output logic                               cancel_en,
    output logic                               fetch_stall,
    output logic                               pc_redir_vld,
    input  logic                               pc_redir_rdy,
    output logic [ADDR_WIDTH-1:0]              pc_redir_pc,
    output logic                               busy
`ifdef TOY_FETCH_REDIRECT_PERF_EN
    ,
    output logic [NUM_SRC-1:0][31:0]           v_perf_redir_cnt,
    output logic [31:0]                        perf_squash_cnt
`endif
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

    redir_state_e  state_q, state_d;
    logic [IW-1:0] active_src_q, active_src_d;
    redir_req_pkg  active_q, active_d;
    logic [CW-1:0] settle_cnt_q, settle_cnt_d;

    logic [NUM_SRC-1:0] gnt;
    logic [IW-1:0]      g_idx;
    logic               g_any;
    logic               accept;
    logic [IW-1:0]      ref_src;
    logic               ref_vld;
    logic [NUM_SRC-1:0] squash;

    toy_fixed_prio_arb #(.N(NUM_SRC), .IW(IW)) u_arb (
        .vld_i (v_redir_req_vld),
        .gnt_o (gnt),
        .idx_o (g_idx),
        .any_o (g_any)
    );

    // A winner is taken when idle, or when it is at least as old as the one in flight.
    assign accept  = g_any && ((state_q == IDLE) || (g_idx <= active_src_q));
    assign ref_src = accept ? g_idx : active_src_q;
    assign ref_vld = accept || (state_q != IDLE);

    // Anything younger than the accepted/active redirect is on a wrong path: squash it.
    always_comb begin
        squash = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            squash[i] = v_redir_req_vld[i] && ref_vld && (IW'(i) > ref_src);
        end
    end

    assign v_redir_req_rdy = (accept ? gnt : '0) | squash;

    // Next state: accept always restarts at CANCEL, including on a REDIRECT handshake cycle.
    always_comb begin
        state_d      = state_q;
        active_src_d = active_src_q;
        active_d     = active_q;
        settle_cnt_d = settle_cnt_q;
        if (accept) begin
            state_d      = CANCEL;
            active_src_d = g_idx;
            active_d.pc  = v_redir_req_pc[g_idx];
        end else begin
            unique case (state_q)
                IDLE:     state_d = IDLE;
                CANCEL: begin
                    settle_cnt_d = SETTLE_LOAD;
                    state_d      = (SETTLE_CYCLES == 0) ? REDIRECT : SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt_q == '0) state_d = REDIRECT;
                    else                    settle_cnt_d = settle_cnt_q - CW'(1);
                end
                REDIRECT: if (pc_redir_rdy) state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // State and tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            active_src_q <= '0;
            active_q     <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            active_src_q <= active_src_d;
            active_q     <= active_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign cancel_en    = (state_q == CANCEL);
    assign fetch_stall  = (state_q != IDLE);
    assign busy         = fetch_stall;
    assign pc_redir_vld = (state_q == REDIRECT);
    assign pc_redir_pc  = active_q.pc;

`ifdef TOY_FETCH_REDIRECT_PERF_EN
    logic [NUM_SRC-1:0][31:0] perf_redir_q;
    logic [31:0]              perf_squash_q;
    logic [31:0]              n_squash;
    logic [32:0]              squash_sum;

    // Number of requests squashed this cycle.
    always_comb begin
        n_squash = '0;
        for (int i = 0; i < NUM_SRC; i++) n_squash = n_squash + 32'(squash[i]);
    end

    assign squash_sum = {1'b0, perf_squash_q} + {1'b0, n_squash};

    // Saturating accept and squash counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_redir_q  <= '0;
            perf_squash_q <= '0;
        end else begin
            if (accept && (perf_redir_q[g_idx] != '1))
                perf_redir_q[g_idx] <= perf_redir_q[g_idx] + 32'd1;
            perf_squash_q <= squash_sum[32] ? '1 : squash_sum[31:0];
        end
    end

    assign v_perf_redir_cnt = perf_redir_q;
    assign perf_squash_cnt  = perf_squash_q;
`else
    // No perf state in this build.
`endif

endmodule

// File: tb/tb_toy_fetch_redirect_ctrl.sv
// Self-checking bench for toy_fetch_redirect_ctrl (NUM_SRC=3, SETTLE_CYCLES=2).
module tb_toy_fetch_redirect_ctrl;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0]      vld;
    logic [2:0]      rdy;
    logic [2:0][31:0] pc;
    logic            cancel_en, fetch_stall, pc_redir_vld, pc_redir_rdy, busy;
    logic [31:0]     pc_redir_pc;
`ifdef TOY_FETCH_REDIRECT_PERF_EN
    logic [2:0][31:0] perf_cnt;
    logic [31:0]      perf_sq;
`endif

    int n_chk = 0;
    int n_pass = 0;
    int cancel_cnt = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    toy_fetch_redirect_ctrl #(.NUM_SRC(3), .SETTLE_CYCLES(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .v_redir_req_vld (vld),
        .v_redir_req_rdy (rdy),
        .v_redir_req_pc  (pc),
        .cancel_en       (cancel_en),
        .fetch_stall     (fetch_stall),
        .pc_redir_vld    (pc_redir_vld),
        .pc_redir_rdy    (pc_redir_rdy),
        .pc_redir_pc     (pc_redir_pc),
        .busy            (busy)
`ifdef TOY_FETCH_REDIRECT_PERF_EN
        ,
        .v_perf_redir_cnt(perf_cnt),
        .perf_squash_cnt (perf_sq)
`endif
    );

    // Scoreboard consumer: every PC hand-off must match the oldest predicted PC.
    always @(negedge clk) begin
        if (rst_n && cancel_en) cancel_cnt++;
        if (rst_n && pc_redir_vld && pc_redir_rdy) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL handoff_unexpected: got pc=%h, expected no hand-off", pc_redir_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (pc_redir_pc !== e) $display("FAIL handoff_pc: got %h, expected %h", pc_redir_pc, e);
                else n_pass++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 20 && busy; i++) step();
        n_chk++;
        if (busy !== 1'b0) $display("FAIL %s_idle_timeout: busy=%b, expected 0", nm, busy);
        else n_pass++;
    endtask

    task automatic check_drained(input string nm);
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL %s_drained: %0d hand-offs missing, expected 0", nm, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vld = '0; pc = '0; pc_redir_rdy = 1'b1;
        #2;
        n_chk++;
        if ({cancel_en, fetch_stall, pc_redir_vld, busy, rdy} !== 7'b0 || pc_redir_pc !== 32'h0)
            $display("FAIL reset_outputs: got c=%b s=%b v=%b b=%b rdy=%b pc=%h, expected all 0",
                     cancel_en, fetch_stall, pc_redir_vld, busy, rdy, pc_redir_pc);
        else n_pass++;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        exp_q.push_back(32'h8000_1000);
        pc[1] = 32'h8000_1000; vld = 3'b010;
        #1;
        n_chk++;
        if (rdy !== 3'b010) $display("FAIL single_rdy: got %b, expected 010", rdy); else n_pass++;
        step();
        vld = '0;
        for (int k = 1; k <= 5; k++) begin
            n_chk++;
            if (cancel_en !== (k == 1) || fetch_stall !== (k <= 4) || pc_redir_vld !== (k == 4) || busy !== (k <= 4))
                $display("FAIL single_T+%0d: got c=%b s=%b v=%b b=%b, expected c=%b s=%b v=%b b=%b", k,
                         cancel_en, fetch_stall, pc_redir_vld, busy, k == 1, k <= 4, k == 4, k <= 4);
            else n_pass++;
            step();
        end
        check_drained("single");
    endtask

    task automatic test_priority();
        int c0;
        c0 = cancel_cnt;
        pc[0] = 32'h100; pc[2] = 32'h200; vld = 3'b101;
        exp_q.push_back(32'h100);
        #1;
        n_chk++;
        if (rdy !== 3'b101) $display("FAIL prio_rdy: got %b, expected 101", rdy); else n_pass++;
        step();
        vld = '0;
        wait_idle("prio");
        n_chk++;
        if (cancel_cnt - c0 != 1) $display("FAIL prio_cancels: got %0d, expected 1", cancel_cnt - c0); else n_pass++;
        check_drained("prio");
    endtask

    task automatic test_preempt_settle();
        int c0;
        c0 = cancel_cnt;
        pc[2] = 32'h2222; vld = 3'b100;
        #1;
        n_chk++;
        if (rdy !== 3'b100) $display("FAIL preempt_rdy2: got %b, expected 100", rdy); else n_pass++;
        step(); vld = '0;
        step();
        pc[0] = 32'h300; vld = 3'b001;
        exp_q.push_back(32'h300);
        #1;
        n_chk++;
        if (rdy !== 3'b001) $display("FAIL preempt_rdy0: got %b, expected 001", rdy); else n_pass++;
        step(); vld = '0;
        n_chk++;
        if (cancel_en !== 1'b1) $display("FAIL preempt_cancel2: got %b, expected 1", cancel_en); else n_pass++;
        step(); step(); step();
        n_chk++;
        if (pc_redir_vld !== 1'b1 || pc_redir_pc !== 32'h300)
            $display("FAIL preempt_T+6: got v=%b pc=%h, expected v=1 pc=00000300", pc_redir_vld, pc_redir_pc);
        else n_pass++;
        wait_idle("preempt");
        n_chk++;
        if (cancel_cnt - c0 != 2) $display("FAIL preempt_cancels: got %0d, expected 2", cancel_cnt - c0); else n_pass++;
        check_drained("preempt");
    endtask

    task automatic test_squash();
        int c0;
        c0 = cancel_cnt;
        pc[1] = 32'h1111; vld = 3'b010;
        exp_q.push_back(32'h1111);
        step(); vld = '0;
        step();
        pc[2] = 32'h2222; vld = 3'b100;
        #1;
        n_chk++;
        if (rdy !== 3'b100) $display("FAIL squash_rdy: got %b, expected 100", rdy); else n_pass++;
        step(); vld = '0;
        n_chk++;
        if (cancel_en !== 1'b0 || fetch_stall !== 1'b1)
            $display("FAIL squash_no_restart: got c=%b s=%b, expected c=0 s=1", cancel_en, fetch_stall);
        else n_pass++;
        wait_idle("squash");
        n_chk++;
        if (cancel_cnt - c0 != 1) $display("FAIL squash_cancels: got %0d, expected 1", cancel_cnt - c0); else n_pass++;
        check_drained("squash");
    endtask

    task automatic test_backpressure();
        pc_redir_rdy = 1'b0;
        pc[0] = 32'h5555; vld = 3'b001;
        exp_q.push_back(32'h5555);
        step(); vld = '0;
        step(); step(); step();
        for (int k = 0; k < 5; k++) begin
            n_chk++;
            if (pc_redir_vld !== 1'b1 || pc_redir_pc !== 32'h5555 || fetch_stall !== 1'b1)
                $display("FAIL bp_hold%0d: got v=%b pc=%h s=%b, expected v=1 pc=00005555 s=1",
                         k, pc_redir_vld, pc_redir_pc, fetch_stall);
            else n_pass++;
            step();
        end
        pc_redir_rdy = 1'b1;
        step();
        n_chk++;
        if (busy !== 1'b0 || pc_redir_vld !== 1'b0)
            $display("FAIL bp_idle: got b=%b v=%b, expected 0 0", busy, pc_redir_vld);
        else n_pass++;
        check_drained("bp");
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = cancel_cnt;
        pc[1] = 32'h7777; vld = 3'b010;
        step();
        pc[0] = 32'h7000; vld = 3'b001;
        exp_q.push_back(32'h7000);
        #1;
        n_chk++;
        if (rdy !== 3'b001 || cancel_en !== 1'b1)
            $display("FAIL b2b_cancel_rdy: got rdy=%b c=%b, expected 001 1", rdy, cancel_en);
        else n_pass++;
        step(); vld = '0;
        n_chk++;
        if (cancel_en !== 1'b1) $display("FAIL b2b_pulse2: got %b, expected 1", cancel_en); else n_pass++;
        wait_idle("b2b");
        n_chk++;
        if (cancel_cnt - c0 != 2) $display("FAIL b2b_cancels: got %0d, expected 2", cancel_cnt - c0); else n_pass++;
        check_drained("b2b");
    endtask

    task automatic test_reset_mid();
        pc[1] = 32'h6666; vld = 3'b010;
        step(); vld = '0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({cancel_en, fetch_stall, pc_redir_vld, busy} !== 4'b0 || pc_redir_pc !== 32'h0)
            $display("FAIL rst_mid_outputs: got c=%b s=%b v=%b b=%b pc=%h, expected all 0",
                     cancel_en, fetch_stall, pc_redir_vld, busy, pc_redir_pc);
        else n_pass++;
        step(); step();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_chk++;
            if (pc_redir_vld !== 1'b0 || busy !== 1'b0)
                $display("FAIL rst_mid_quiet%0d: got v=%b b=%b, expected 0 0", k, pc_redir_vld, busy);
            else n_pass++;
            step();
        end
        check_drained("rst_mid");
    endtask

`ifdef TOY_FETCH_REDIRECT_PERF_EN
    task automatic test_perf();
        for (int r = 0; r < 3; r++) begin
            pc[1] = 32'h900 + r; vld = 3'b010;
            exp_q.push_back(32'h900 + r);
            step(); vld = '0;
            if (r == 0) begin
                step();
                vld = 3'b100;
                step(); vld = '0;
            end
            wait_idle("perf");
        end
        n_chk++;
        if (perf_cnt[1] !== 32'd3 || perf_cnt[0] !== 32'd0 || perf_sq !== 32'd1)
            $display("FAIL perf_counts: got cnt1=%0d cnt0=%0d sq=%0d, expected 3 0 1", perf_cnt[1], perf_cnt[0], perf_sq);
        else n_pass++;
        check_drained("perf");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_preempt_settle();
        test_squash();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef TOY_FETCH_REDIRECT_PERF_EN
        test_perf();
`endif
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
